// File: rtl/exp5_unidade_controle.sv
// Moore control unit for the memory game: sequences address/round counters and the
// play register, judges each play, and ends the game on error, win or per-play timeout.
module exp5_unidade_controle #(
  parameter int unsigned TIMEOUT = 5000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada,
  input  logic       igual,
  input  logic       fimE,
  input  logic       fimL,
  output logic       zeraE,
  output logic       contaE,
  output logic       zeraL,
  output logic       contaL,
  output logic       zeraR,
  output logic       registraR,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic [3:0] db_estado
);

  localparam logic [3:0] INICIAL        = 4'h0;
  localparam logic [3:0] PREPARACAO     = 4'h1;
  localparam logic [3:0] INICIO_RODADA  = 4'h2;
  localparam logic [3:0] ESPERA_JOGADA  = 4'h3;
  localparam logic [3:0] REGISTRA       = 4'h4;
  localparam logic [3:0] COMPARACAO     = 4'h5;
  localparam logic [3:0] PROXIMO        = 4'h6;
  localparam logic [3:0] PROXIMA_RODADA = 4'h7;
  localparam logic [3:0] FIM_ACERTOU    = 4'hC;
  localparam logic [3:0] FIM_ERROU      = 4'hD;
  localparam logic [3:0] FIM_TIMEOUT    = 4'hE;

  localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT - 1);

  logic [3:0]    estado_atual;
  logic [3:0]    proximo_estado;
  logic [TW-1:0] timer;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_atual <= INICIAL;
    end else begin
      estado_atual <= proximo_estado;
    end
  end

  // Counts only while waiting for a play; any other state clears it, so every
  // entry into espera_jogada starts a fresh window.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      timer <= '0;
    end else if (estado_atual == ESPERA_JOGADA) begin
      timer <= timer + 1'b1;
    end else begin
      timer <= '0;
    end
  end

  always_comb begin
    proximo_estado = INICIAL;
    case (estado_atual)
      INICIAL:        proximo_estado = iniciar ? PREPARACAO : INICIAL;
      PREPARACAO:     proximo_estado = INICIO_RODADA;
      INICIO_RODADA:  proximo_estado = ESPERA_JOGADA;
      ESPERA_JOGADA: begin
        if (jogada)                  proximo_estado = REGISTRA;
        else if (timer == TIMER_MAX) proximo_estado = FIM_TIMEOUT;
        else                         proximo_estado = ESPERA_JOGADA;
      end
      REGISTRA:       proximo_estado = COMPARACAO;
      COMPARACAO: begin
        if (!igual)     proximo_estado = FIM_ERROU;
        else if (!fimE) proximo_estado = PROXIMO;
        else if (!fimL) proximo_estado = PROXIMA_RODADA;
        else            proximo_estado = FIM_ACERTOU;
      end
      PROXIMO:        proximo_estado = ESPERA_JOGADA;
      PROXIMA_RODADA: proximo_estado = INICIO_RODADA;
      FIM_ACERTOU:    proximo_estado = iniciar ? PREPARACAO : FIM_ACERTOU;
      FIM_ERROU:      proximo_estado = iniciar ? PREPARACAO : FIM_ERROU;
      FIM_TIMEOUT:    proximo_estado = iniciar ? PREPARACAO : FIM_TIMEOUT;
      default:        proximo_estado = INICIAL;
    endcase
  end

  always_comb begin
    zeraE     = 1'b0;
    contaE    = 1'b0;
    zeraL     = 1'b0;
    contaL    = 1'b0;
    zeraR     = 1'b0;
    registraR = 1'b0;
    pronto    = 1'b0;
    acertou   = 1'b0;
    errou     = 1'b0;
    timeout   = 1'b0;
    case (estado_atual)
      PREPARACAO: begin
        zeraE = 1'b1;
        zeraL = 1'b1;
        zeraR = 1'b1;
      end
      INICIO_RODADA:  zeraE     = 1'b1;
      REGISTRA:       registraR = 1'b1;
      PROXIMO:        contaE    = 1'b1;
      PROXIMA_RODADA: contaL    = 1'b1;
      FIM_ACERTOU: begin
        pronto  = 1'b1;
        acertou = 1'b1;
      end
      FIM_ERROU: begin
        pronto = 1'b1;
        errou  = 1'b1;
      end
      FIM_TIMEOUT: begin
        pronto  = 1'b1;
        errou   = 1'b1;
        timeout = 1'b1;
      end
      default: ;
    endcase
  end

  assign db_estado = estado_atual;

endmodule
